axi4lite_reg_slave: RTL and testbench

AXI4LITE_REG_SLAVE -- requirements
Module: axi4lite_reg_slave

---
 rtl/axi4lite_reg_slave.sv | 118 +++++++++++
 tb/tb_axi4lite_reg_slave.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing four 32-bit registers with byte strobes,
// independent read/write paths and per-register write pulses.
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_out,
  output logic [3:0]                      wr_strobe
);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          awready_q;
  logic                          wready_q;
  logic                          bvalid_q;
  logic                          arready_q;
  logic                          rvalid_q;
  logic [3:0]                    wr_strobe_q;

  logic [1:0] wrIdx;
  logic [1:0] rdIdx;
  logic       wrAccept;
  logic       wrFire;
  logic       rdAccept;
  logic       rdFire;

  // Only the word index selects a register; prot and byte offset bits are don't-care.
  assign wrIdx    = s00_axi_awaddr[3:2];
  assign rdIdx    = s00_axi_araddr[3:2];
  assign wrAccept = s00_axi_awvalid && s00_axi_wvalid && !awready_q && !bvalid_q;
  assign wrFire   = awready_q && s00_axi_awvalid && s00_axi_wvalid;
  assign rdAccept = s00_axi_arvalid && !arready_q && !rvalid_q;
  assign rdFire   = arready_q && s00_axi_arvalid;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      wr_strobe_q <= 4'b0000;
    end else begin
      awready_q   <= wrAccept;
      wready_q    <= wrAccept;
      wr_strobe_q <= 4'b0000;
      if (wrFire) begin
        for (int k = 0; k < C_S_AXI_DATA_WIDTH / 8; k++) begin
          if (s00_axi_wstrb[k]) regs_q[wrIdx][8*k +: 8] <= s00_axi_wdata[8*k +: 8];
        end
        bvalid_q    <= 1'b1;
        wr_strobe_q <= 4'b0001 << wrIdx;
      end else if (bvalid_q && s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read data is captured from the pre-update register value, so a
  // write landing on the same edge is not visible to this read.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= rdAccept;
      if (rdFire) begin
        rdata_q  <= regs_q[rdIdx];
        rvalid_q <= 1'b1;
      end else if (rvalid_q && s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign wr_strobe       = wr_strobe_q;
  assign reg0_out        = regs_q[0];
  assign reg1_out        = regs_q[1];
  assign reg2_out        = regs_q[2];
  assign reg3_out        = regs_q[3];

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Scoreboard-driven bench for axi4lite_reg_slave: read expectations are
// queued when a read is issued and popped when rvalid delivers data.
module tb_axi4lite_reg_slave;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;
  logic [3:0]  wr_strobe;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model [4];
  logic [31:0] expQ [$];

  axi4lite_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out), .reg3_out(reg3_out),
    .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] regOut(input int idx);
    case (idx)
      0: return reg0_out;
      1: return reg1_out;
      2: return reg2_out;
      default: return reg3_out;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write with bready high; returns what the B channel showed.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [3:0] strobeSeen,
                          output logic [1:0] respSeen, output bit ok);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ok = 1'b0; strobeSeen = 4'hx; respSeen = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (awready && wready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      ok = bvalid;
      strobeSeen = wr_strobe;
      respSeen = bresp;
      tick();
    end else begin
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [3:0] addr, output logic [31:0] dataSeen,
                         output logic [1:0] respSeen, output bit ok);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    ok = 1'b0; dataSeen = 32'hx; respSeen = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (arready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      tick();
      arvalid = 1'b0;
      ok = rvalid;
      dataSeen = rdata;
      respSeen = rresp;
      tick();
    end else begin
      arvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    awaddr = '0; awprot = 3'b101; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = 3'b010; arvalid = 1'b0; rready = 1'b0;
    tick(); tick();
    total++;
    if ({reg0_out, reg1_out, reg2_out, reg3_out} !== 128'h0) begin
      bad++; $display("[TB] FAIL reset_regs got=%h required=0", {reg0_out, reg1_out, reg2_out, reg3_out});
    end
    total++;
    if ({awready, wready, arready, bvalid, rvalid, wr_strobe} !== 9'h0) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b required=0", {awready, wready, arready, bvalid, rvalid, wr_strobe});
    end
    total++;
    if ({rdata, bresp, rresp} !== 36'h0) begin
      bad++; $display("[TB] FAIL reset_data got=%h required=0", {rdata, bresp, rresp});
    end
    areset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    tick();
  endtask

  task automatic test_write_read();
    logic [3:0] s; logic [1:0] r; logic [31:0] d; logic [31:0] e; bit ok;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i * 4), 32'(i + 1), 4'hF, s, r, ok);
      model[i] = merge(model[i], 32'(i + 1), 4'hF);
      total++;
      if (!ok || s !== (4'b0001 << i) || r !== 2'b00) begin
        bad++; $display("[TB] FAIL write_%0d ok=%0d strobe=%b resp=%b required strobe=%b", i, ok, s, r, 4'b0001 << i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(model[i]);
      do_read(4'(i * 4), d, r, ok);
      e = expQ.pop_front();
      total++;
      if (!ok || d !== e || r !== 2'b00) begin
        bad++; $display("[TB] FAIL read_%0d ok=%0d got=%h resp=%b required=%h", i, ok, d, r, e);
      end
    end
  endtask

  task automatic test_byte_strobe();
    logic [3:0] s; logic [1:0] r; bit ok;
    do_write(4'h4, 32'hAABBCCDD, 4'hF, s, r, ok);
    do_write(4'h5, 32'h11223344, 4'h5, s, r, ok);
    model[1] = merge(merge(model[1], 32'hAABBCCDD, 4'hF), 32'h11223344, 4'h5);
    total++;
    if (reg1_out !== 32'hAA22CC44 || !ok || s !== 4'b0010) begin
      bad++; $display("[TB] FAIL byte_strobe got=%h strobe=%b required=aa22cc44", reg1_out, s);
    end
  endtask

  task automatic test_w_before_aw();
    bit ok;
    awaddr = 4'hC; wdata = 32'hCAFE0003; wstrb = 4'hF; bready = 1'b1;
    wvalid = 1'b1; awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (wready !== 1'b0 || awready !== 1'b0) begin
        bad++; $display("[TB] FAIL w_early_%0d wready=%b awready=%b required=0", i, wready, awready);
      end
    end
    awvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (awready && wready) begin ok = 1'b1; break; end
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    model[3] = 32'hCAFE0003;
    total++;
    if (!ok || bvalid !== 1'b1 || wr_strobe !== 4'b1000 || reg3_out !== 32'hCAFE0003) begin
      bad++; $display("[TB] FAIL w_early_done ok=%0d bvalid=%b strobe=%b reg3=%h", ok, bvalid, wr_strobe, reg3_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0] pat; logic [8:0] expPat;
    awaddr = 4'h8; wdata = 32'h0000B2B2; wstrb = 4'hF; bready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      pat[k-1] = awready;
      expPat[k-1] = (k % 3 == 1);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    model[2] = 32'h0000B2B2;
    total++;
    if (pat !== expPat) begin
      bad++; $display("[TB] FAIL b2b_write got=%b required=%b", pat, expPat);
    end
    araddr = 4'h8; rready = 1'b1; arvalid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      pat[k-1] = arready;
    end
    arvalid = 1'b0;
    total++;
    if (pat !== expPat) begin
      bad++; $display("[TB] FAIL b2b_read got=%b required=%b", pat, expPat);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok; logic [31:0] e; logic [31:0] held;
    awaddr = 4'h0; wdata = 32'h00000A0A; wstrb = 4'hF; bready = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (awready) begin ok = 1'b1; break; end
    end
    tick();
    awaddr = 4'h4; wdata = 32'h00000B0B;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (!ok || bvalid !== 1'b1 || awready !== 1'b0) begin
        bad++; $display("[TB] FAIL bp_wait_%0d bvalid=%b awready=%b required 1,0", i, bvalid, awready);
      end
      if (i < 4) tick();
    end
    bready = 1'b1;
    tick();
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_release bvalid=%b awready=%b required 0,0", bvalid, awready);
    end
    tick();
    total++;
    if (awready !== 1'b1) begin
      bad++; $display("[TB] FAIL bp_second_accept awready=%b required=1", awready);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    model[0] = 32'h00000A0A; model[1] = 32'h00000B0B;
    total++;
    if (bvalid !== 1'b1 || wr_strobe !== 4'b0010 || reg0_out !== model[0] || reg1_out !== model[1]) begin
      bad++; $display("[TB] FAIL bp_second_done bvalid=%b strobe=%b reg0=%h reg1=%h", bvalid, wr_strobe, reg0_out, reg1_out);
    end
    tick();

    expQ.push_back(model[0]);
    expQ.push_back(model[1]);
    araddr = 4'h0; rready = 1'b0; arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (arready) begin ok = 1'b1; break; end
    end
    tick();
    araddr = 4'h4;
    held = rdata;
    e = expQ.pop_front();
    total++;
    if (!ok || rvalid !== 1'b1 || held !== e) begin
      bad++; $display("[TB] FAIL rbp_first rvalid=%b got=%h required=%h", rvalid, held, e);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== e) begin
        bad++; $display("[TB] FAIL rbp_wait_%0d rvalid=%b arready=%b rdata=%h required %h", i, rvalid, arready, rdata, e);
      end
    end
    rready = 1'b1;
    tick();
    tick();
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      bad++; $display("[TB] FAIL rbp_second_accept rvalid=%b arready=%b required 0,1", rvalid, arready);
    end
    tick();
    arvalid = 1'b0;
    e = expQ.pop_front();
    total++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      bad++; $display("[TB] FAIL rbp_second_data rvalid=%b got=%h required=%h", rvalid, rdata, e);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    logic [3:0] s; logic [1:0] r; logic [31:0] d; logic [31:0] e; bit ok;
    do_write(4'h8, 32'h5, 4'hF, s, r, ok);
    model[2] = 32'h5;
    expQ.push_back(model[2]);
    awaddr = 4'h8; wdata = 32'h9; wstrb = 4'hF; bready = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; rready = 1'b1; arvalid = 1'b1;
    tick();
    total++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      bad++; $display("[TB] FAIL same_accept awready=%b arready=%b required 1,1", awready, arready);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[2] = 32'h9;
    e = expQ.pop_front();
    total++;
    if (rvalid !== 1'b1 || rdata !== e || bvalid !== 1'b1 || reg2_out !== 32'h9) begin
      bad++; $display("[TB] FAIL same_cycle rdata=%h required=%h rvalid=%b bvalid=%b reg2=%h", rdata, e, rvalid, bvalid, reg2_out);
    end
    tick();
    expQ.push_back(model[2]);
    do_read(4'h8, d, r, ok);
    e = expQ.pop_front();
    total++;
    if (!ok || d !== e) begin
      bad++; $display("[TB] FAIL same_reread got=%h required=%h", d, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] s; logic [1:0] r; logic [31:0] d; logic [31:0] e; bit ok;
    awaddr = 4'h0; wdata = 32'h7; wstrb = 4'hF; bready = 1'b0; awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (awready) begin ok = 1'b1; break; end
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    total++;
    if (!ok || bvalid !== 1'b1 || reg0_out !== 32'h7) begin
      bad++; $display("[TB] FAIL rst_mid_pre bvalid=%b reg0=%h required 1,7", bvalid, reg0_out);
    end
    areset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    total++;
    if (bvalid !== 1'b0 || reg0_out !== 32'h0 || reg3_out !== 32'h0) begin
      bad++; $display("[TB] FAIL rst_mid bvalid=%b reg0=%h reg3=%h required 0", bvalid, reg0_out, reg3_out);
    end
    areset = 1'b0;
    bready = 1'b1;
    do_write(4'h0, 32'h00001234, 4'h3, s, r, ok);
    model[0] = merge(model[0], 32'h00001234, 4'h3);
    total++;
    if (!ok || s !== 4'b0001 || reg0_out !== model[0]) begin
      bad++; $display("[TB] FAIL rst_mid_after ok=%0d strobe=%b reg0=%h required=%h", ok, s, reg0_out, model[0]);
    end
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(model[i]);
      do_read(4'(i * 4 + 1), d, r, ok);
      e = expQ.pop_front();
      total++;
      if (!ok || d !== e || regOut(i) !== model[i]) begin
        bad++; $display("[TB] FAIL final_read_%0d got=%h reg=%h required=%h", i, d, regOut(i), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_w_before_aw();
    test_back_to_back();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
